// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch stage with a decoupling prefetch queue
//
// Issues sequential fetches to a synchronous instruction SRAM, buffers up to
// DEPTH returned {pc, inst} pairs and hands them to ID over valid/ready.
// A redirect (br_e) discards in-flight and queued work and restarts at br_addr.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   stall[STALL_W-1:0]  pipeline stall vector, bit 0 blocks new fetches
//   br_bus[32:0]        {br_e, br_addr}
//   id_ready            ID accepts the head entry
//   if_to_id_valid/bus  head entry {pc, inst}
//   inst_sram_*         SRAM request; rdata valid the cycle after en
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 4,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  input  logic               id_ready,
  output logic               if_to_id_valid,
  output logic [63:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  input  logic [31:0]        inst_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   queue [DEPTH];

  logic          br_e;
  logic [31:0]   br_addr;
  logic [OW-1:0] occupancy;
  logic          issue;
  logic          capture;
  logic          pop;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];

  // Reserve a slot for every outstanding request; a same-cycle pop is
  // deliberately ignored so the issue path never depends on id_ready.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = !br_e && !stall[0] && (occupancy < OW'(DEPTH));

  assign capture = inflight;
  assign pop     = if_to_id_valid && id_ready;

  assign inst_sram_en    = issue;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  assign if_to_id_valid = (count != '0);
  assign if_to_id_bus   = queue[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (br_e) begin
      // Redirect: the pending SRAM response is dropped by clearing inflight.
      fetch_pc <= br_addr;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
        inflight    <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      if (capture) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (capture && !br_e) queue[wr_ptr] <= {inflight_pc, inst_sram_rdata};
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized self-checking bench for if_prefetch (DEPTH 4, 2, 5)
module tb_if_prefetch;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;
  localparam int N = 3;
  localparam int DEP [N] = '{4, 2, 5};
  localparam int CYCLES = 2500;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  stall = '0;
  logic [32:0] br_bus = '0;
  logic        id_ready = 1'b1;

  logic        valid [N];
  logic [63:0] bus   [N];
  logic        en    [N];
  logic [3:0]  wen   [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];

  int compared = 0;
  int mismatched = 0;

  // Reference state: next fetch pc, outstanding request, and queued pcs.
  logic [31:0] m_fpc [N];
  logic [31:0] m_ipc [N];
  bit          m_infl [N];
  logic [31:0] mq [N][$];

  always #5 clk = ~clk;

  if_prefetch #(.RESET_PC(RST_PC), .DEPTH(4), .STALL_W(6)) u_d4 (
    .clk(clk), .resetn(resetn), .stall(stall), .br_bus(br_bus), .id_ready(id_ready),
    .if_to_id_valid(valid[0]), .if_to_id_bus(bus[0]), .inst_sram_en(en[0]),
    .inst_sram_wen(wen[0]), .inst_sram_addr(addr[0]), .inst_sram_wdata(wdata[0]),
    .inst_sram_rdata(rdata[0]));

  if_prefetch #(.RESET_PC(RST_PC), .DEPTH(2), .STALL_W(6)) u_d2 (
    .clk(clk), .resetn(resetn), .stall(stall), .br_bus(br_bus), .id_ready(id_ready),
    .if_to_id_valid(valid[1]), .if_to_id_bus(bus[1]), .inst_sram_en(en[1]),
    .inst_sram_wen(wen[1]), .inst_sram_addr(addr[1]), .inst_sram_wdata(wdata[1]),
    .inst_sram_rdata(rdata[1]));

  if_prefetch #(.RESET_PC(RST_PC), .DEPTH(5), .STALL_W(6)) u_d5 (
    .clk(clk), .resetn(resetn), .stall(stall), .br_bus(br_bus), .id_ready(id_ready),
    .if_to_id_valid(valid[2]), .if_to_id_bus(bus[2]), .inst_sram_en(en[2]),
    .inst_sram_wen(wen[2]), .inst_sram_addr(addr[2]), .inst_sram_wdata(wdata[2]),
    .inst_sram_rdata(rdata[2]));

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Synchronous SRAM: data for the requested address appears next cycle;
  // garbage otherwise, so a wrongly captured slot shows up.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      rdata[k] <= en[k] ? sram_word(addr[k]) : $urandom();
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_fpc[k]  = RST_PC;
      m_ipc[k]  = '0;
      m_infl[k] = 1'b0;
      mq[k].delete();
    end
  endtask

  task automatic drive(input int c);
    logic [31:0] r;
    resetn   = 1'b1;
    stall    = '0;
    br_bus   = '0;
    id_ready = 1'b1;
    r = $urandom();
    if (c < 2) resetn = 1'b0;
    else if (c < 30) ;                              // clean stream
    else if (c < 40) id_ready = 1'b0;               // back-pressure fills queues
    else if (c < 60) ;                              // drain in order
    else if (c == 60) br_bus = {1'b1, 32'h8000_0100};
    else if (c == 68) br_bus = {1'b1, 32'hffff_fff8}; // pc wrap through zero
    else if (c >= 80 && c < 83) stall[0] = 1'b1;
    else if (c == 90) begin stall[0] = 1'b1; br_bus = {1'b1, 32'h0000_2000}; end
    else if (c > 100) begin
      id_ready = ($urandom_range(0, 3) != 0);
      stall    = 6'($urandom_range(0, 63));
      stall[0] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) br_bus = {1'b1, r[31:2], 2'b00};
      if ($urandom_range(0, 149) == 0) resetn = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < CYCLES; c++) begin
      bit exp_en [N];
      @(negedge clk);
      drive(c);
      if (!resetn) model_reset();
      #1;
      for (int k = 0; k < N; k++) begin
        int occ;
        occ = mq[k].size() + int'(m_infl[k]);
        exp_en[k] = !br_bus[32] && !stall[0] && (occ < DEP[k]);
        check($sformatf("en_d%0d", DEP[k]), 64'(en[k]), 64'(exp_en[k]));
        check($sformatf("addr_d%0d", DEP[k]), 64'(addr[k]), 64'(m_fpc[k]));
        check($sformatf("valid_d%0d", DEP[k]), 64'(valid[k]), 64'(mq[k].size() != 0));
        if (mq[k].size() != 0)
          check($sformatf("bus_d%0d", DEP[k]), bus[k], {mq[k][0], sram_word(mq[k][0])});
        if (c % 64 == 0) begin
          check($sformatf("wen_d%0d", DEP[k]), 64'(wen[k]), 64'(0));
          check($sformatf("wdata_d%0d", DEP[k]), 64'(wdata[k]), 64'(0));
        end
      end
      @(posedge clk);
      if (resetn) begin
        for (int k = 0; k < N; k++) begin
          bit do_pop;
          do_pop = (mq[k].size() != 0) && id_ready;
          if (br_bus[32]) begin
            mq[k].delete();
            m_infl[k] = 1'b0;
            m_fpc[k]  = br_bus[31:0];
          end else begin
            if (do_pop) void'(mq[k].pop_front());
            if (m_infl[k]) mq[k].push_back(m_ipc[k]);
            if (exp_en[k]) begin
              m_ipc[k]  = m_fpc[k];
              m_fpc[k]  = m_fpc[k] + 32'd4;
              m_infl[k] = 1'b1;
            end else begin
              m_infl[k] = 1'b0;
            end
          end
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
